uart_tx_module: RTL and testbench



---
 rtl/uart_tx_module_pkg.sv | 19 +
 rtl/uart_tx_module.sv | 111 +++++++++++
 tb/tb_uart_tx_module.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_module_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constant,
// reused by both the TX and RX controllers.
package uart_tx_module_pkg;

  localparam int OS_TICKS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  // Counter width for 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_module.sv
// 8N1 UART transmitter driven by a 16x oversampling tick: start bit,
// LSB-first data bits, then a stop bit of configurable tick length.
module uart_tx_module
  import uart_tx_module_pkg::*;
#(
  parameter int NB_TXMODULE_DATA    = 8,
  parameter int SB_TXMODULE_TICKS   = 16,
  parameter int NB_TXMODULE_TICKCNT = 5
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_txmodule_start,
  input  logic                        i_txmodule_tick,
  input  logic [NB_TXMODULE_DATA-1:0] i_txmodule_data,
  output logic                        o_txmodule_tx,
  output logic                        o_txmodule_busy,
  output logic                        o_txmodule_donetick
);

  localparam int NB_BITCNT = cnt_w(NB_TXMODULE_DATA);
  localparam logic [NB_TXMODULE_TICKCNT-1:0] OS_LAST = NB_TXMODULE_TICKCNT'(OS_TICKS - 1);
  localparam logic [NB_TXMODULE_TICKCNT-1:0] SB_LAST = NB_TXMODULE_TICKCNT'(SB_TXMODULE_TICKS - 1);
  localparam logic [NB_BITCNT-1:0]           N_LAST  = NB_BITCNT'(NB_TXMODULE_DATA - 1);

  uart_state_e                    state, state_nxt;
  logic [NB_TXMODULE_TICKCNT-1:0] s, s_nxt;
  logic [NB_BITCNT-1:0]           n, n_nxt;
  logic [NB_TXMODULE_DATA-1:0]    b, b_nxt;
  logic                           tx, tx_nxt;
  logic                           done;

  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    n_nxt     = n;
    b_nxt     = b;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (i_txmodule_start) begin
          b_nxt     = i_txmodule_data;
          s_nxt     = '0;
          state_nxt = START;
        end
      end
      START: begin
        if (i_txmodule_tick) begin
          if (s == OS_LAST) begin
            s_nxt     = '0;
            n_nxt     = '0;
            state_nxt = DATA;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_txmodule_tick) begin
          if (s == OS_LAST) begin
            s_nxt = '0;
            b_nxt = b >> 1;
            if (n == N_LAST) state_nxt = STOP;
            else             n_nxt     = n + 1'b1;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_txmodule_tick) begin
          if (s == SB_LAST) begin
            state_nxt = IDLE;
            done      = 1'b1;
          end else begin
            s_nxt = s + 1'b1;
          end
        end
      end
    endcase

    // Line level follows the state being entered, so tx moves on the same
    // edge as the state change instead of lagging it by a cycle.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = b_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      n     <= n_nxt;
      b     <= b_nxt;
      tx    <= tx_nxt;
    end
  end

  assign o_txmodule_tx       = tx;
  assign o_txmodule_busy     = (state != IDLE);
  // A reset that lands on the final stop tick aborts the frame: no done.
  assign o_txmodule_donetick = done & ~i_reset;

endmodule

// File: tb/tb_uart_tx_module.sv
// Scoreboard bench for uart_tx_module: expected line levels are queued when a
// frame is started and compared per bit-period as the serial line is observed.
module tb_uart_tx_module;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx0, busy0, done0;
  logic       tx1, busy1, done1;

  logic       tick_hold = 1'b0;
  logic       tick_en = 1'b0;
  int         tcnt = 0;

  int         asserts = 0;
  int         fails = 0;
  logic       exp_q[$];

  uart_tx_module #(.NB_TXMODULE_DATA(8), .SB_TXMODULE_TICKS(16), .NB_TXMODULE_TICKCNT(5)) dut (
    .i_clk(clk), .i_reset(reset), .i_txmodule_start(start), .i_txmodule_tick(tick),
    .i_txmodule_data(data), .o_txmodule_tx(tx0), .o_txmodule_busy(busy0),
    .o_txmodule_donetick(done0));

  uart_tx_module #(.NB_TXMODULE_DATA(8), .SB_TXMODULE_TICKS(32), .NB_TXMODULE_TICKCNT(5)) dut32 (
    .i_clk(clk), .i_reset(reset), .i_txmodule_start(start), .i_txmodule_tick(tick),
    .i_txmodule_data(data), .o_txmodule_tx(tx1), .o_txmodule_busy(busy1),
    .o_txmodule_donetick(done1));

  always #5 clk = ~clk;

  // Tick every 4 clocks, or held high; updated just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % 4;
      tick = tick_hold || (tick_en && tcnt == 0);
    end
  end

  // Called at a negedge with the DUT idle; acceptance happens on the next posedge.
  task automatic send(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    exp_q.push_back(1'b1);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consumes the scoreboard while watching one frame; returns at the negedge
  // of the donetick cycle. Optionally injects a 0xFF start at tick inject_at.
  task automatic monitor_frame(input int sel, input int sb, input int inject_at);
    int   t = 0, lvl = -1, idx, cyc = 0, t_done = -1;
    logic ctx, cbusy, cdone, obs = 1'b0, exp_b = 1'b0, glitch = 1'b0, busy_bad = 1'b0;
    logic inj_done = 1'b0, inj_clr = 1'b0;
    while (t_done < 0 && cyc < 3000) begin
      ctx   = sel ? tx1 : tx0;
      cbusy = sel ? busy1 : busy0;
      cdone = sel ? done1 : done0;
      idx   = (t < 144) ? t / 16 : 9;
      if (idx != lvl) begin
        if (lvl >= 0) begin
          asserts++;
          if (obs !== exp_b || glitch !== 1'b0) begin
            fails++;
            $display("FAIL level%0d: got %b (glitch=%b), expected steady %b", lvl, obs, glitch, exp_b);
          end
        end
        if (exp_q.size() == 0) begin
          asserts++; fails++;
          $display("FAIL scoreboard: level %0d observed, expected none queued", idx);
          exp_b = 1'bx;
        end else begin
          exp_b = exp_q.pop_front();
        end
        obs = ctx; glitch = 1'b0; lvl = idx;
      end else if (ctx !== obs) begin
        glitch = 1'b1;
      end
      if (cbusy !== 1'b1) busy_bad = 1'b1;
      if (inj_clr) begin
        start = 1'b0; inj_clr = 1'b0;
      end else if (inject_at >= 0 && t == inject_at && !inj_done) begin
        start = 1'b1; data = 8'hFF; inj_done = 1'b1; inj_clr = 1'b1;
      end
      if (cdone === 1'b1) t_done = t + 1;
      if (tick) t++;
      if (t_done < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    asserts++;
    if (obs !== exp_b || glitch !== 1'b0) begin
      fails++;
      $display("FAIL level%0d: got %b (glitch=%b), expected steady %b", lvl, obs, glitch, exp_b);
    end
    asserts++;
    if (t_done !== 144 + sb) begin
      fails++;
      $display("FAIL frame_len: donetick at tick %0d, expected %0d", t_done, 144 + sb);
    end
    asserts++;
    if (busy_bad !== 1'b0) begin
      fails++;
      $display("FAIL busy_in_frame: busy dropped during frame, expected high throughout");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick_hold = 1'b1;
    repeat (3) @(negedge clk);
    asserts++;
    if ({tx0, busy0, done0} !== 3'b100) begin
      fails++;
      $display("FAIL reset_outputs: tx/busy/done=%b, expected 100", {tx0, busy0, done0});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    asserts++;
    if ({tx0, busy0, done0, tx1, busy1} !== 5'b10010) begin
      fails++;
      $display("FAIL reset_tick_hold: outputs=%b, expected 10010", {tx0, busy0, done0, tx1, busy1});
    end
    tick_hold = 1'b0; tick_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    send(8'hA5);
    monitor_frame(0, 16, -1);
    @(negedge clk);
    asserts++;
    if ({busy0, done0, tx0} !== 3'b001) begin
      fails++;
      $display("FAIL single_after: busy/done/tx=%b, expected 001", {busy0, done0, tx0});
    end
  endtask

  task automatic test_back_to_back();
    send(8'h3C);
    monitor_frame(0, 16, -1);
    start = 1'b1; data = 8'h3C;   // donetick cycle: must be ignored
    @(negedge clk);
    asserts++;
    if ({busy0, tx0} !== 2'b01) begin
      fails++;
      $display("FAIL b2b_ignored: busy/tx=%b, expected 01", {busy0, tx0});
    end
    send(8'h3C);
    monitor_frame(0, 16, -1);
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    send(8'h00);
    monitor_frame(0, 16, 50);
    @(negedge clk);
    asserts++;
    if ({busy0, done0, tx0} !== 3'b001) begin
      fails++;
      $display("FAIL busy_start: busy/done/tx=%b, expected 001", {busy0, done0, tx0});
    end
    repeat (8) @(negedge clk);
    asserts++;
    if (busy0 !== 1'b0) begin
      fails++;
      $display("FAIL busy_start_queued: busy=%b, expected 0", busy0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int t = 0, cyc = 0, dcnt = 0;
    send(8'hA5);
    while (t < 40 && cyc < 1000) begin
      if (tick) t++;
      @(negedge clk);
      cyc++;
    end
    asserts++;
    if (t !== 40) begin
      fails++;
      $display("FAIL midrst_ticks: reached %0d ticks, expected 40", t);
    end
    asserts++;
    if (tx0 === 1'b1 && busy0 === 1'b1) begin
      fails++;
      $display("FAIL midrst_pre: tx=%b at tick 40, expected 0 (data bit 1 of 0xA5)", tx0);
    end
    reset = 1'b1;
    @(negedge clk);
    asserts++;
    if ({tx0, busy0, done0} !== 3'b100) begin
      fails++;
      $display("FAIL midrst_line: tx/busy/done=%b, expected 100", {tx0, busy0, done0});
    end
    reset = 1'b0;
    exp_q.delete();
    repeat (200) begin
      @(negedge clk);
      if (done0) dcnt++;
    end
    asserts++;
    if (dcnt !== 0) begin
      fails++;
      $display("FAIL midrst_done: %0d donetick pulses, expected 0", dcnt);
    end
    send(8'h81);
    monitor_frame(0, 16, -1);
    @(negedge clk);
  endtask

  task automatic test_stop_length();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    asserts++;
    if ({tx1, busy1} !== 2'b10) begin
      fails++;
      $display("FAIL sb32_idle: tx/busy=%b, expected 10", {tx1, busy1});
    end
    send(8'h55);
    monitor_frame(1, 32, -1);
    @(negedge clk);
    asserts++;
    if ({busy1, tx1} !== 2'b01) begin
      fails++;
      $display("FAIL sb32_after: busy/tx=%b, expected 01", {busy1, tx1});
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_frame();
    test_stop_length();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
